// File: rtl/concat_serializer.sv
// Serializes one {x2, x1} pair per input handshake as an LSB-first frame under
// a valid/ready output handshake, with an idle gap after each frame.
module concat_serializer #(
  parameter int X1_W       = 11,
  parameter int X2_W       = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [X1_W-1:0] x1_i,
  input  logic [X2_W-1:0] x2_i,
  output logic            ser_out_o,
  output logic            ser_valid_o,
  output logic            ser_last_o,
  input  logic            out_ready_i,
  output logic            busy_o,
  output logic [7:0]      frame_cnt_o
);

  localparam int FW       = X1_W + X2_W;
  localparam int IW       = $clog2(FW);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   shreg_q, shreg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      cnt_q, cnt_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: capture in IDLE, shift on accept, count out the gap.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          shreg_d = {x2_i, x1_i};
          idx_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (out_ready_i) begin
          shreg_d = {1'b0, shreg_q[FW-1:1]};
          if (idx_q == IW'(FW - 1)) begin
            idx_d   = '0;
            gap_d   = '0;
            cnt_d   = cnt_q + 8'd1;
            state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // in_ready must drop while reset is held, so it also looks at rst_ni.
  assign in_ready_o  = rst_ni && (state_q == ST_IDLE);
  assign ser_valid_o = (state_q == ST_SHIFT);
  assign ser_out_o   = ser_valid_o & shreg_q[0];
  assign ser_last_o  = ser_valid_o && (idx_q == IW'(FW - 1));
  assign busy_o      = (state_q != ST_IDLE);
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_concat_serializer.sv
// Bench for concat_serializer: two instances (GAP_CYCLES 0 and 1) checked
// every cycle against a frame/position model, plus literal spot checks.
module tb_concat_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  in_valid_v;
  logic [10:0] x1;
  logic [7:0]  x2;
  logic        out_ready;

  logic [1:0]  in_ready_w, ser_out_w, ser_valid_w, ser_last_w, busy_w;
  logic [7:0]  fcnt0, fcnt1;

  int nerr = 0;
  int nchk = 0;

  concat_serializer #(.X1_W(11), .X2_W(8), .GAP_CYCLES(0)) u_gap0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_v[0]), .in_ready_o(in_ready_w[0]),
    .x1_i(x1), .x2_i(x2), .ser_out_o(ser_out_w[0]), .ser_valid_o(ser_valid_w[0]),
    .ser_last_o(ser_last_w[0]), .out_ready_i(out_ready), .busy_o(busy_w[0]),
    .frame_cnt_o(fcnt0)
  );

  concat_serializer #(.X1_W(11), .X2_W(8), .GAP_CYCLES(1)) u_gap1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_v[1]), .in_ready_o(in_ready_w[1]),
    .x1_i(x1), .x2_i(x2), .ser_out_o(ser_out_w[1]), .ser_valid_o(ser_valid_w[1]),
    .ser_last_o(ser_last_w[1]), .out_ready_i(out_ready), .busy_o(busy_w[1]),
    .frame_cnt_o(fcnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the captured frame, the index of the bit on the wire, gap cycles left.
  logic [18:0] fr [2];
  int  pos [2];
  bit  act [2];
  int  gap_left [2];
  int  cnt [2];
  int  done [2];
  int  caps [2];

  function automatic int gapv(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      fr[i] = '0; pos[i] = 0; act[i] = 1'b0; gap_left[i] = 0;
      cnt[i] = 0; done[i] = 0; caps[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          act[i] = 1'b0; pos[i] = 0; gap_left[i] = 0; cnt[i] = 0; done[i] = 0; caps[i] = 0;
        end else if (act[i]) begin
          if (out_ready) begin
            if (pos[i] == 18) begin
              act[i] = 1'b0;
              cnt[i] = (cnt[i] + 1) % 256;
              done[i]++;
              gap_left[i] = gapv(i);
            end else begin
              pos[i]++;
            end
          end
        end else if (gap_left[i] > 0) begin
          gap_left[i]--;
        end else if (in_valid_v[i]) begin
          fr[i] = {x2, x1};
          pos[i] = 0;
          act[i] = 1'b1;
          caps[i]++;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("g%0d_in_ready", gapv(i)), {31'd0, in_ready_w[i]},
            {31'd0, rst_n && !act[i] && (gap_left[i] == 0)});
        chk($sformatf("g%0d_ser_valid", gapv(i)), {31'd0, ser_valid_w[i]}, {31'd0, act[i]});
        chk($sformatf("g%0d_ser_out", gapv(i)), {31'd0, ser_out_w[i]},
            {31'd0, act[i] ? fr[i][pos[i]] : 1'b0});
        chk($sformatf("g%0d_ser_last", gapv(i)), {31'd0, ser_last_w[i]},
            {31'd0, act[i] && (pos[i] == 18)});
        chk($sformatf("g%0d_busy", gapv(i)), {31'd0, busy_w[i]},
            {31'd0, act[i] || (gap_left[i] > 0)});
        chk($sformatf("g%0d_frame_cnt", gapv(i)), {24'd0, (i == 0) ? fcnt0 : fcnt1}, cnt[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sends one frame to both instances and records what the GAP_CYCLES=1 one emits.
  task automatic run_frame(input logic [10:0] a, input logic [7:0] b, input int stall_at,
                           input int stall_len, input bit noisy, output logic [18:0] got,
                           output int lat1, output int lat0, output int nlast, output int lpos);
    int nb;
    int stalled;
    got = '0; nb = 0; stalled = 0; lat1 = -1; lat0 = -1; nlast = 0; lpos = -1;
    x1 = a; x2 = b; in_valid_v = 2'b11; out_ready = 1'b1;
    tick();
    in_valid_v = noisy ? 2'b11 : 2'b00;
    for (int c = 1; c <= 200 && lat1 < 0; c++) begin
      if (noisy) begin
        x1 = 11'($urandom);
        x2 = 8'($urandom);
      end
      if (lat0 < 0 && in_ready_w[0]) lat0 = c;
      if (in_ready_w[1]) begin
        lat1 = c;
        in_valid_v = 2'b00;
      end else begin
        if (ser_valid_w[1] && nb == stall_at && stalled < stall_len) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
        end
        if (ser_valid_w[1] && out_ready && nb < 19) begin
          got[nb] = ser_out_w[1];
          if (ser_last_w[1]) begin
            nlast++;
            lpos = nb;
          end
          nb++;
        end
        tick();
      end
    end
    if (lat1 < 0) chk("frame_timeout", 32'd1, 32'd0);
    out_ready = 1'b1;
    in_valid_v = 2'b00;
  endtask

  int seq [19] = '{1,0,1,0,0,1,0,1,1,0,1,1,1,0,0,0,0,1,1};

  initial begin
    logic [18:0] got;
    logic [18:0] expv;
    logic [18:0] frm;
    logic [10:0] ra;
    logic [7:0]  rb;
    int l1, l0, nl, lp;
    int cyc;

    rst_n = 1'b0; in_valid_v = 2'b11; x1 = 11'h0; x2 = 8'h0; out_ready = 1'b1;
    for (int k = 0; k < 19; k++) expv[k] = seq[k][0];

    // Reset held with in_valid high.
    repeat (3) tick();
    chk("rst_in_ready", {30'd0, in_ready_w}, 32'd0);
    chk("rst_ser_valid", {30'd0, ser_valid_w}, 32'd0);
    chk("rst_ser_out", {30'd0, ser_out_w}, 32'd0);
    chk("rst_ser_last", {30'd0, ser_last_w}, 32'd0);
    chk("rst_busy", {30'd0, busy_w}, 32'd0);
    chk("rst_fcnt", {24'd0, fcnt1}, 32'd0);
    rst_n = 1'b1; in_valid_v = 2'b00;
    #1;
    chk("rel_in_ready", {30'd0, in_ready_w}, 32'd3);
    tick();
    chk("rel_fcnt", {24'd0, fcnt1}, 32'd0);

    // Basic frame.
    run_frame(11'h5A5, 8'hC3, -1, 0, 1'b0, got, l1, l0, nl, lp);
    chk("basic_seq", {13'd0, got}, {13'd0, expv});
    chk("basic_nlast", nl, 32'd1);
    chk("basic_last_pos", lp, 32'd18);
    chk("basic_latency", l1, 32'd21);
    chk("gap0_latency", l0, 32'd20);
    chk("basic_fcnt", {24'd0, fcnt1}, 32'd1);

    // Backpressure at bit 7 for 5 cycles.
    run_frame(11'h5A5, 8'hC3, 7, 5, 1'b0, got, l1, l0, nl, lp);
    chk("stall_seq", {13'd0, got}, {13'd0, expv});
    chk("stall_latency", l1, 32'd26);
    chk("stall_gap0_latency", l0, 32'd25);
    chk("stall_fcnt", {24'd0, fcnt1}, 32'd2);

    // Inputs toggling with in_valid high during the frame.
    run_frame(11'h2B4, 8'h9D, -1, 0, 1'b1, got, l1, l0, nl, lp);
    frm = {8'h9D, 11'h2B4};
    chk("iso_seq", {13'd0, got}, {13'd0, frm});
    chk("iso_latency", l1, 32'd21);
    chk("iso_fcnt", {24'd0, fcnt1}, 32'd3);

    // Reset while bit 10 is on the wire.
    x1 = 11'h3A7; x2 = 8'h5E; in_valid_v = 2'b11; out_ready = 1'b1;
    frm = {8'h5E, 11'h3A7};
    tick();
    in_valid_v = 2'b00;
    repeat (10) tick();
    chk("mid_bit10_valid", {31'd0, ser_valid_w[1]}, 32'd1);
    chk("mid_bit10", {31'd0, ser_out_w[1]}, {31'd0, frm[10]});
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", {31'd0, ser_valid_w[1]}, 32'd0);
    chk("mid_rst_fcnt", {24'd0, fcnt1}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", {31'd0, in_ready_w[1]}, 32'd1);
    tick();
    ra = 11'($urandom); rb = 8'($urandom);
    run_frame(ra, rb, -1, 0, 1'b0, got, l1, l0, nl, lp);
    chk("post_rst_seq", {13'd0, got}, {13'd0, rb, ra});
    chk("post_rst_fcnt", {24'd0, fcnt1}, 32'd1);

    // 257 random frames per instance with random backpressure.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cyc = 0;
    while (!(done[0] == 257 && done[1] == 257) && cyc < 30000) begin
      for (int i = 0; i < 2; i++)
        in_valid_v[i] = (caps[i] < 257 && $urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      x1 = 11'($urandom);
      x2 = 8'($urandom);
      out_ready = ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    if (cyc >= 30000) chk("wrap_timeout", 32'd1, 32'd0);
    in_valid_v = 2'b00; out_ready = 1'b1;
    repeat (3) tick();
    chk("wrap_fcnt_g0", {24'd0, fcnt0}, 32'd1);
    chk("wrap_fcnt_g1", {24'd0, fcnt1}, 32'd1);
    chk("wrap_idle", {30'd0, in_ready_w}, 32'd3);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
